// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO (rclk domain).
// Pulls words from the FIFO memory while it is not empty and presents them
// on a registered valid/ready stream through a 2-entry skid buffer.
// The read request depends only on registered state, rempty and reset,
// never on m_ready, so no combinational path crosses to the pointer logic.
module fifo_rd_stream #(
    parameter int unsigned data_size = 8,
    parameter int unsigned cnt_size  = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rempty,
    input  logic [data_size-1:0] rdata,
    output logic                 rinc,
    output logic                 m_valid,
    output logic [data_size-1:0] m_data,
    input  logic                 m_ready,
    output logic [1:0]           buf_level,
    output logic [cnt_size-1:0]  beat_cnt
);

    // Buffer occupancy doubles as the controller state
    typedef enum logic [1:0] {
        LVL_EMPTY = 2'd0,
        LVL_ONE   = 2'd1,
        LVL_TWO   = 2'd2
    } level_e;

    level_e                state_q, state_d;
    logic [data_size-1:0]  slot0_q, slot0_d;   // head, drives m_data
    logic [data_size-1:0]  slot1_q, slot1_d;   // skid entry
    logic                  m_valid_q, m_valid_d;
    logic [cnt_size-1:0]   beat_cnt_q, beat_cnt_d;

    logic push;
    logic pop;

    // Read request: only registered state, empty flag and reset feed it
    always_comb begin
        push = rrst & ~rempty & (state_q != LVL_TWO);
        pop  = m_valid_q & m_ready;
    end

    // Next-state, slot moves and beat counter
    always_comb begin
        state_d    = state_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        beat_cnt_d = beat_cnt_q;

        if (pop) begin
            beat_cnt_d = beat_cnt_q + cnt_size'(1);
        end

        case (state_q)
            LVL_EMPTY: begin
                if (push) begin
                    slot0_d = rdata;
                    state_d = LVL_ONE;
                end
            end
            LVL_ONE: begin
                if (push && pop) begin
                    slot0_d = rdata;
                end else if (push) begin
                    slot1_d = rdata;
                    state_d = LVL_TWO;
                end else if (pop) begin
                    state_d = LVL_EMPTY;
                end
            end
            LVL_TWO: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    state_d = LVL_ONE;
                end
            end
            default: begin
                state_d = LVL_EMPTY;
            end
        endcase

        m_valid_d = (state_d != LVL_EMPTY);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge rclk) begin
        if (!rrst) begin
            state_q    <= LVL_EMPTY;
            slot0_q    <= '0;
            slot1_q    <= '0;
            m_valid_q  <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            m_valid_q  <= m_valid_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output mapping
    always_comb begin
        rinc      = push;
        m_valid   = m_valid_q;
        m_data    = slot0_q;
        buf_level = state_q;
        beat_cnt  = beat_cnt_q;
    end

endmodule
